tjrpu_wb_arbiter: RTL and testbench



---
 rtl/tjrpu_wb_arbiter.sv | 81 ++++++++
 tb/tb_tjrpu_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tjrpu_wb_arbiter.sv
// tjrpu_wb_arbiter: round-robin two-master Wishbone arbiter holding the grant for a whole cyc.
// Define ARB_TIMEOUT_EN to abort stalled transfers with a one-cycle bus error after TIMEOUT waits.
module tjrpu_wb_arbiter #(
  parameter int AW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic last, g0, g1, stb_sel, err;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) last <= state_nx == GNT1;
    end
  // on a tie the master that was not granted last time wins
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (m0_cyc_i && (!m1_cyc_i || last)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (g0 ? !m0_cyc_i : !m1_cyc_i)
      state_nx = IDLE;
  end
  assign stb_sel  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o  = stb_sel & ~err;
  assign s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & err;
  assign m1_err_o = g1 & err;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // an ack at the terminal count wins over the error
  assign err = stb_sel && !s_ack_i && cnt == CW'(TIMEOUT);
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) cnt <= '0;
    else cnt <= (state == IDLE || s_ack_i || err) ? '0 : s_stb_o ? cnt + 1'b1 : cnt;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tjrpu_wb_arbiter.sv
// tb_tjrpu_wb_arbiter: scoreboard bench for tjrpu_wb_arbiter; slave-side and ack-side queues
// are filled by the directed tests and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_tjrpu_wb_arbiter;
  localparam int AW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] cyc = '0, stb = '0, we = '0;
  logic [3:0] sel [2];
  logic [31:0] adr [2], wd [2];
  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i, s_adr_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0] s_sel_o;
  int total = 0, bad = 0;
  int ack_delay = 0, wait_cnt = 0;
  logic ack_force = 1'b0;

  tjrpu_wb_arbiter #(.AW(AW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wd[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wd[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  // slave model: a request is cyc with a nonzero sel (masters zero sel while stb is low),
  // which keeps the ack independent of the arbiter's error-gated stb
  logic req;
  assign req = s_cyc_o && (s_sel_o != 4'h0);
  assign s_ack_i = req && (ack_force || wait_cnt == ack_delay);
  assign s_dat_i = ~s_adr_o;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= 0;
    else wait_cnt <= (req && !s_ack_i) ? wait_cnt + 1 : 0;

  typedef struct { logic [31:0] adr, dat; logic we; logic [3:0] sel; } sx_t;
  typedef struct { int m; logic [31:0] dat; } ax_t;
  sx_t sq[$];
  ax_t aq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_x(input int m, input logic [31:0] a, input logic [31:0] d, input logic w, input int n);
    for (int i = 0; i < n; i++) begin
      sq.push_back('{adr: a + 32'(4 * i), dat: d + 32'(i), we: w, sel: 4'hF});
      aq.push_back('{m: m, dat: ~(a + 32'(4 * i))});
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    sx_t e;
    ax_t x;
    if (s_cyc_o && s_stb_o && s_ack_i) begin
      if (sq.size() == 0) chk("slave_unexpected", s_adr_o, 32'hXXXX_XXXX);
      else begin
        e = sq.pop_front();
        chk("slave_adr", s_adr_o, e.adr);
        chk("slave_dat", s_dat_o, e.dat);
        chk("slave_we", 32'(s_we_o), 32'(e.we));
        chk("slave_sel", 32'(s_sel_o), 32'(e.sel));
      end
    end
    for (int m = 0; m < 2; m++)
      if (m == 0 ? m0_ack_o : m1_ack_o) begin
        if (aq.size() == 0) chk("ack_unexpected", 32'(m), 32'hFFFF_FFFF);
        else begin
          x = aq.pop_front();
          chk("ack_master", 32'(m), 32'(x.m));
          chk("ack_rdata", m == 0 ? m0_dat_o : m1_dat_o, x.dat);
        end
      end
  end

  task automatic run(input int m, input logic [31:0] a, input logic [31:0] d, input logic w, input int n);
    int t;
    @(posedge clk); #1;
    cyc[m] = 1'b1;
    we[m] = w;
    for (int i = 0; i < n; i++) begin
      stb[m] = 1'b1; sel[m] = 4'hF; adr[m] = a + 32'(4 * i); wd[m] = d + 32'(i);
      t = 0;
      do begin @(negedge clk); t++; end while (!(m == 0 ? m0_ack_o : m1_ack_o) && t < 100);
      if (t >= 100) chk("ack_wait_timeout", 32'(m), 32'hFFFF_FFFF);
      @(posedge clk); #1;
      stb[m] = 1'b0; sel[m] = 4'h0;
      if (i < n - 1) begin @(posedge clk); #1; end
    end
    cyc[m] = 1'b0;
    we[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin sel[m] = 4'h0; adr[m] = '0; wd[m] = '0; end
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 0);
    chk("rst_m0_ack", 32'(m0_ack_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_cyc", 32'(s_cyc_o), 0);
    chk("idle_s_stb", 32'(s_stb_o), 0);
    chk("idle_s_adr", s_adr_o, 0);
    chk("idle_err", 32'({m0_err_o, m1_err_o}), 0);
    // single m0 write, one cycle grant latency, combinational ack
    expect_x(0, 32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 1);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3000_0010; wd[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lat_s_cyc_pre", 32'(s_cyc_o), 0);
    @(negedge clk);
    chk("wr_s_cyc", 32'(s_cyc_o), 1);
    chk("wr_s_adr", s_adr_o, 32'h3000_0010);
    chk("wr_s_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("wr_m0_ack", 32'(m0_ack_o), 1);
    chk("wr_m1_ack", 32'(m1_ack_o), 0);
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; sel[0] = 4'h0;
    @(negedge clk);
    chk("rel_s_cyc", 32'(s_cyc_o), 0);
    // m1 burst of 3 stb pulses in one cyc; m0 must wait until it ends
    expect_x(1, 32'h3000_0100, 32'h1111_0000, 1'b0, 3);
    expect_x(0, 32'h3000_0200, 32'h2222_0000, 1'b1, 1);
    fork
      run(1, 32'h3000_0100, 32'h1111_0000, 1'b0, 3);
      begin @(posedge clk); run(0, 32'h3000_0200, 32'h2222_0000, 1'b1, 1); end
    join
    // asynchronous reset in the middle of an m1 transfer
    ack_delay = 1000;
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h3000_0300;
    repeat (2) @(negedge clk);
    chk("mid_s_cyc", 32'(s_cyc_o), 1);
    @(posedge clk); #2;
    ack_force = 1'b1;
    #1;
    chk("mid_m1_ack", 32'(m1_ack_o), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", 32'(s_cyc_o), 0);
    chk("arst_s_stb", 32'(s_stb_o), 0);
    chk("arst_m1_ack", 32'(m1_ack_o), 0);
    chk("arst_m1_dat", m1_dat_o, 32'hFFFF_FFFF);
    cyc[1] = 1'b0; stb[1] = 1'b0; sel[1] = 4'h0;
    ack_force = 1'b0; ack_delay = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // tie after reset goes to m0, then strict alternation m0, m1, m0, m1
    expect_x(0, 32'h3000_0400, 32'hA000_0000, 1'b1, 1);
    expect_x(1, 32'h3000_0500, 32'hB000_0000, 1'b0, 1);
    expect_x(0, 32'h3000_0600, 32'hC000_0000, 1'b1, 1);
    expect_x(1, 32'h3000_0700, 32'hD000_0000, 1'b0, 1);
    fork
      begin run(0, 32'h3000_0400, 32'hA000_0000, 1'b1, 1); run(0, 32'h3000_0600, 32'hC000_0000, 1'b1, 1); end
      begin run(1, 32'h3000_0500, 32'hB000_0000, 1'b0, 1); run(1, 32'h3000_0700, 32'hD000_0000, 1'b0, 1); end
    join
    // stalled slave
    ack_delay = 1000;
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'h3000_0020;
    @(negedge clk);
    chk("stall_s_cyc_pre", 32'(s_cyc_o), 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("to_err_c%0d", i), 32'(m0_err_o), (i == 5) ? 1 : 0);
      chk($sformatf("to_stb_c%0d", i), 32'(s_stb_o), (i == 5) ? 0 : 1);
      chk($sformatf("to_cyc_c%0d", i), 32'(s_cyc_o), 1);
    end
`else
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("hold_err_c%0d", i), 32'(m0_err_o), 0);
      chk($sformatf("hold_stb_c%0d", i), 32'(s_stb_o), 1);
    end
`endif
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0; sel[0] = 4'h0;
    // slave acks exactly at the terminal count: ack only
    ack_delay = 4;
    expect_x(0, 32'h3000_0030, 32'h0, 1'b0, 1);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'h3000_0030; wd[0] = 32'h0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("late_ack_c%0d", i), 32'(m0_ack_o), (i == 5) ? 1 : 0);
      chk($sformatf("late_err_c%0d", i), 32'(m0_err_o), 0);
    end
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0; sel[0] = 4'h0;
    repeat (2) @(negedge clk);
    chk("sq_drained", 32'(sq.size()), 0);
    chk("aq_drained", 32'(aq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
